dma_controller: RTL and testbench

DMA_CONTROLLER -- requirements
Module: dma_controller

---
 rtl/dma_controller_pkg.sv | 36 +++
 rtl/dma_controller_regs.sv | 96 +++++++++
 rtl/dma_controller.sv | 161 ++++++++++++++++
 tb/tb_dma_controller.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_controller_pkg.sv
// Shared definitions for the DMA controller.
//   state_t        : transfer FSM encoding (IDLE, RD, CAP, WR, YIELD)
//   REG_*          : register offsets from the DMA_ADDRESS base in the 0x10xx IO page
//   CTRL_*         : bit positions inside a CTRL write
//   len_to_count() : converts the programmed LEN byte into a byte count
package dma_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_CAP   = 3'd2,
    ST_WR    = 3'd3,
    ST_YIELD = 3'd4
  } state_t;

  localparam logic [7:0] IO_PAGE   = 8'h10;
  localparam logic [7:0] REG_COUNT = 8'd6;

  localparam logic [2:0] REG_SRC_L = 3'd0;
  localparam logic [2:0] REG_SRC_H = 3'd1;
  localparam logic [2:0] REG_DST_L = 3'd2;
  localparam logic [2:0] REG_DST_H = 3'd3;
  localparam logic [2:0] REG_LEN   = 3'd4;
  localparam logic [2:0] REG_CTRL  = 3'd5;

  localparam int CTRL_START    = 0;
  localparam int CTRL_HOLD_SRC = 1;
  localparam int CTRL_HOLD_DST = 2;
  localparam int CTRL_ABORT    = 7;

  // LEN of zero encodes a full 256-byte block, hence the 9-bit count.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/dma_controller_regs.sv
// dma_regs: programming registers, address decode and read mux.
//   clk, rst            : clock, asynchronous active-high reset
//   cpu_*               : CPU bus request (address, write data, write/read enables)
//   grant               : CPU currently owns the bus (not stalled)
//   busy, done_flag     : live status from the transfer FSM
//   src, dst, len       : programmed source, destination and length
//   start, abort        : one-cycle command strobes decoded from a CTRL write
//   hold_src, hold_dst  : hold bits of the CTRL write, valid with start
//   dout                : registered read data, zero when no register is read
module dma_regs
  import dma_controller_pkg::*;
#(
  parameter logic [7:0] DMA_ADDRESS = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_w_en,
  input  logic        cpu_r_en,
  input  logic        grant,
  input  logic        busy,
  input  logic        done_flag,
  output logic [15:0] src,
  output logic [15:0] dst,
  output logic [7:0]  len,
  output logic        start,
  output logic        abort,
  output logic        hold_src,
  output logic        hold_dst,
  output logic [7:0]  dout
);

  logic [7:0] offset;
  logic [2:0] reg_sel;
  logic       hit;
  logic       wr;
  logic       rd;
  logic       ctrl_wr;
  logic [7:0] rdata;

  // A frozen CPU keeps presenting its request; it only reaches the
  // registers on the cycle it actually owns the bus.
  assign offset  = cpu_address[7:0] - DMA_ADDRESS;
  assign reg_sel = offset[2:0];
  assign hit     = grant && (cpu_address[15:8] == IO_PAGE) && (offset < REG_COUNT);
  assign wr      = hit && cpu_w_en;
  assign rd      = hit && cpu_r_en;
  assign ctrl_wr = wr && (reg_sel == REG_CTRL);

  // Abort wins over a start carried in the same write.
  assign abort    = ctrl_wr && cpu_din[CTRL_ABORT];
  assign start    = ctrl_wr && cpu_din[CTRL_START] && !cpu_din[CTRL_ABORT] && !busy;
  assign hold_src = cpu_din[CTRL_HOLD_SRC];
  assign hold_dst = cpu_din[CTRL_HOLD_DST];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src <= 16'h0000;
      dst <= 16'h0000;
      len <= 8'h00;
    end else if (wr && !busy) begin
      case (reg_sel)
        REG_SRC_L: src[7:0]  <= cpu_din;
        REG_SRC_H: src[15:8] <= cpu_din;
        REG_DST_L: dst[7:0]  <= cpu_din;
        REG_DST_H: dst[15:8] <= cpu_din;
        REG_LEN:   len       <= cpu_din;
        default:   ;
      endcase
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (reg_sel)
      REG_SRC_L: rdata = src[7:0];
      REG_SRC_H: rdata = src[15:8];
      REG_DST_L: rdata = dst[7:0];
      REG_DST_H: rdata = dst[15:8];
      REG_LEN:   rdata = len;
      REG_CTRL:  rdata = {6'b000000, busy, done_flag};
      default:   rdata = 8'h00;
    endcase
  end

  // dout is OR-combined with other IO, so it must idle at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= 8'h00;
    end else begin
      dout <= rd ? rdata : 8'h00;
    end
  end

endmodule

// File: rtl/dma_controller.sv
// dma_controller: single-channel memory-to-memory DMA with cycle stealing.
// Each byte costs RD, CAP, WR (CPU stalled) followed by one YIELD cycle in
// which the CPU gets the bus back; the final byte skips YIELD.
//   clk, rst                          : clock, asynchronous active-high reset
//   cpu_address/din/w_en/r_en         : CPU bus request
//   bus_address/din/w_en/r_en         : arbitrated bus to the memory/IO decoder
//   bus_dout                          : read data from the memory/IO decoder
//   dout                              : register read data (zero when idle)
//   cpu_stall                         : CPU must freeze while high
//   done_flag, done_flag_clr          : completion interrupt and its clear pulse
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter logic [7:0] DMA_ADDRESS = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_w_en,
  input  logic        cpu_r_en,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_din,
  output logic        bus_w_en,
  output logic        bus_r_en,
  input  logic [7:0]  bus_dout,
  output logic [7:0]  dout,
  output logic        cpu_stall,
  output logic        done_flag,
  input  logic        done_flag_clr
);

  state_t      state;
  logic [15:0] src_w;
  logic [15:0] dst_w;
  logic [8:0]  count;
  logic [7:0]  data;
  logic        hold_src_w;
  logic        hold_dst_w;

  logic        busy;
  logic        last_byte;
  logic [15:0] src;
  logic [15:0] dst;
  logic [7:0]  len;
  logic        start;
  logic        abort;
  logic        hold_src;
  logic        hold_dst;

  assign cpu_stall = (state == ST_RD) || (state == ST_CAP) || (state == ST_WR);
  assign busy      = (state != ST_IDLE);
  assign last_byte = (state == ST_WR) && (count == 9'd1);

  dma_regs #(
    .DMA_ADDRESS (DMA_ADDRESS)
  ) u_regs (
    .clk         (clk),
    .rst         (rst),
    .cpu_address (cpu_address),
    .cpu_din     (cpu_din),
    .cpu_w_en    (cpu_w_en),
    .cpu_r_en    (cpu_r_en),
    .grant       (!cpu_stall),
    .busy        (busy),
    .done_flag   (done_flag),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .start       (start),
    .abort       (abort),
    .hold_src    (hold_src),
    .hold_dst    (hold_dst),
    .dout        (dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      src_w      <= 16'h0000;
      dst_w      <= 16'h0000;
      count      <= 9'd0;
      data       <= 8'h00;
      hold_src_w <= 1'b0;
      hold_dst_w <= 1'b0;
      done_flag  <= 1'b0;
    end else begin
      // A completion on the same edge as a clear keeps the flag set.
      if (last_byte && !abort) begin
        done_flag <= 1'b1;
      end else if (done_flag_clr) begin
        done_flag <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_RD;
            src_w      <= src;
            dst_w      <= dst;
            count      <= len_to_count(len);
            hold_src_w <= hold_src;
            hold_dst_w <= hold_dst;
          end
        end
        ST_RD: begin
          state <= ST_CAP;
        end
        ST_CAP: begin
          data  <= bus_dout;
          state <= ST_WR;
        end
        ST_WR: begin
          if (!hold_src_w) src_w <= src_w + 16'd1;
          if (!hold_dst_w) dst_w <= dst_w + 16'd1;
          count <= count - 9'd1;
          state <= (count == 9'd1) ? ST_IDLE : ST_YIELD;
        end
        ST_YIELD: begin
          state <= ST_RD;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Abort overrides the next-state choice; the WR bus cycle itself is
      // combinational, so a write already on the bus still happens.
      if (abort) state <= ST_IDLE;
    end
  end

  always_comb begin
    bus_address = cpu_address;
    bus_din     = cpu_din;
    bus_w_en    = cpu_w_en;
    bus_r_en    = cpu_r_en;
    case (state)
      ST_RD: begin
        bus_address = src_w;
        bus_din     = 8'h00;
        bus_w_en    = 1'b0;
        bus_r_en    = 1'b1;
      end
      ST_CAP: begin
        bus_address = src_w;
        bus_din     = 8'h00;
        bus_w_en    = 1'b0;
        bus_r_en    = 1'b0;
      end
      ST_WR: begin
        bus_address = dst_w;
        bus_din     = data;
        bus_w_en    = 1'b1;
        bus_r_en    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: a memory model answers the bus,
// a reference model predicts every DMA write into a queue, and a monitor
// pops and compares each write the DUT puts on the bus.
module tb_dma_controller;

  localparam logic [15:0] RB = 16'h1010;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_din;
  logic        cpu_w_en;
  logic        cpu_r_en;
  logic [15:0] bus_address;
  logic [7:0]  bus_din;
  logic        bus_w_en;
  logic        bus_r_en;
  logic [7:0]  bus_dout;
  logic [7:0]  dout;
  logic        cpu_stall;
  logic        done_flag;
  logic        done_flag_clr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t expq[$];

  logic [7:0] rnd_tab [0:255];
  logic [7:0] mem     [0:65535];
  bit         written [0:65535];
  logic [7:0] rdata;

  always #5 clk = ~clk;

  dma_controller #(.DMA_ADDRESS(8'h10)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_address   (cpu_address),
    .cpu_din       (cpu_din),
    .cpu_w_en      (cpu_w_en),
    .cpu_r_en      (cpu_r_en),
    .bus_address   (bus_address),
    .bus_din       (bus_din),
    .bus_w_en      (bus_w_en),
    .bus_r_en      (bus_r_en),
    .bus_dout      (bus_dout),
    .dout          (dout),
    .cpu_stall     (cpu_stall),
    .done_flag     (done_flag),
    .done_flag_clr (done_flag_clr)
  );

  // Unwritten locations hold a pseudo-random pattern derived from the address.
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return rnd_tab[a[7:0]] ^ a[15:8];
  endfunction

  // Synchronous memory: read data appears the cycle after the read strobe.
  assign bus_dout = rdata;
  always @(posedge clk) begin
    if (bus_r_en) rdata <= written[bus_address] ? mem[bus_address] : init_byte(bus_address);
    if (bus_w_en) begin
      mem[bus_address]     <= bus_din;
      written[bus_address] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (cpu_stall && bus_w_en) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dma_write: got write addr 0x%0h data 0x%0h expected none",
                   bus_address, bus_din);
        end else begin
          e = expq.pop_front();
          check("dma_wr_addr", bus_address, e.a);
          check("dma_wr_data", bus_din, e.d);
        end
      end
    end
  endtask

  // All bus tasks start and finish just after a falling edge.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_address = a;
    cpu_din     = d;
    cpu_w_en    = 1'b1;
    @(negedge clk);
    cpu_w_en    = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    cpu_address = a;
    cpu_r_en    = 1'b1;
    @(negedge clk);
    cpu_r_en    = 1'b0;
    d           = dout;
  endtask

  task automatic program_regs(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l);
    cpu_write(RB + 16'd0, s[7:0]);
    cpu_write(RB + 16'd1, s[15:8]);
    cpu_write(RB + 16'd2, d[7:0]);
    cpu_write(RB + 16'd3, d[15:8]);
    cpu_write(RB + 16'd4, l);
  endtask

  // Reference model: byte i reads src(+i) and writes dst(+i), n bytes total.
  task automatic push_expected(input logic [15:0] s, input logic [15:0] d, input int n,
                               input bit hs, input bit hd);
    logic [15:0] sa;
    logic [15:0] da;
    wr_t e;
    for (int i = 0; i < n; i++) begin
      sa  = hs ? s : s + 16'(i);
      da  = hd ? d : d + 16'(i);
      e.a = da;
      e.d = init_byte(sa);
      expq.push_back(e);
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done_flag && cycles < 3000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    @(negedge clk);
  endtask

  task automatic clear_done();
    done_flag_clr = 1'b1;
    @(negedge clk);
    done_flag_clr = 1'b0;
  endtask

  task automatic check_regs_zero(input string tag);
    logic [7:0] v;
    for (int r = 0; r < 6; r++) begin
      cpu_read(RB + 16'(r), v);
      check({tag, "_reg"}, v, 8'h00);
    end
  endtask

  initial begin
    logic [7:0]  v;
    logic [15:0] s;
    logic [15:0] d;
    logic [7:0]  l;
    logic [7:0]  pat [0:4];
    bit          hs;
    bit          hd;
    int          n;
    int          cyc;

    for (int i = 0; i < 256; i++) rnd_tab[i] = 8'($urandom);
    rst           = 1'b1;
    cpu_address   = 16'h0000;
    cpu_din       = 8'h00;
    cpu_w_en      = 1'b0;
    cpu_r_en      = 1'b0;
    done_flag_clr = 1'b0;
    fork
      monitor();
    join_none

    // Reset state and passthrough while held in reset.
    repeat (3) @(negedge clk);
    cpu_address = 16'h5A3C;
    #1;
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_done", done_flag, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_pass_addr", bus_address, 16'h5A3C);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_regs_zero("post_rst");

    // Register write/readback and idle dout.
    for (int i = 0; i < 5; i++) pat[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) cpu_write(RB + 16'(i), pat[i]);
    for (int i = 0; i < 5; i++) begin
      cpu_read(RB + 16'(i), v);
      check("reg_readback", v, pat[i]);
    end
    @(negedge clk);
    check("dout_idle_zero", dout, 8'h00);

    // Combinational passthrough while the CPU owns the bus.
    for (int i = 0; i < 3; i++) begin
      cpu_address = 16'($urandom_range(0, 16'hFFFF));
      cpu_din     = 8'($urandom);
      cpu_r_en    = 1'b1;
      #1;
      check("pass_addr", bus_address, cpu_address);
      check("pass_din", bus_din, cpu_din);
      check("pass_r_en", bus_r_en, 1'b1);
      check("pass_w_en", bus_w_en, 1'b0);
      cpu_r_en = 1'b0;
      @(negedge clk);
    end

    // Three-byte copy: 3*3 + 2 yield cycles.
    program_regs(16'h0010, 16'h2000, 8'd3);
    push_expected(16'h0010, 16'h2000, 3, 1'b0, 1'b0);
    cpu_write(RB + 16'd5, 8'h01);
    wait_done(cyc);
    check("copy3_cycles", cyc, 11);
    check("copy3_done", done_flag, 1'b1);
    check("copy3_queue", expq.size(), 0);
    cpu_read(RB + 16'd5, v);
    check("copy3_status", v, 8'h01);
    clear_done();
    check("copy3_cleared", done_flag, 1'b0);

    // Source wraps from 0xFFFF to 0x0000.
    program_regs(16'hFFFF, 16'h2100, 8'd2);
    push_expected(16'hFFFF, 16'h2100, 2, 1'b0, 1'b0);
    cpu_write(RB + 16'd5, 8'h01);
    wait_done(cyc);
    check("wrap_cycles", cyc, 7);
    check("wrap_queue", expq.size(), 0);
    clear_done();

    // LEN=0 is 256 bytes into one held IO address; a start issued in the
    // first yield is ignored.
    program_regs(16'h0200, 16'h1020, 8'd0);
    push_expected(16'h0200, 16'h1020, 256, 1'b0, 1'b1);
    cpu_write(RB + 16'd5, 8'h05);
    repeat (3) @(negedge clk);
    check("full_yield1_stall", cpu_stall, 1'b0);
    cpu_write(RB + 16'd5, 8'h01);
    wait_done(cyc);
    check("full_cycles_after_yield1", cyc, 1023 - 4);
    check("full_done", done_flag, 1'b1);
    check("full_queue", expq.size(), 0);
    clear_done();

    // Abort in the yield after byte 2 of 5; a register write in the first
    // yield is ignored.
    program_regs(16'h0345, 16'h8000, 8'd5);
    push_expected(16'h0345, 16'h8000, 2, 1'b0, 1'b0);
    cpu_write(RB + 16'd5, 8'h01);
    repeat (3) @(negedge clk);
    check("abort_yield1_stall", cpu_stall, 1'b0);
    cpu_write(RB + 16'd0, 8'hAA);
    repeat (3) @(negedge clk);
    check("abort_yield2_stall", cpu_stall, 1'b0);
    cpu_write(RB + 16'd5, 8'h80);
    check("abort_stall", cpu_stall, 1'b0);
    cpu_read(RB + 16'd5, v);
    check("abort_status", v, 8'h00);
    repeat (10) @(negedge clk);
    check("abort_done", done_flag, 1'b0);
    check("abort_queue", expq.size(), 0);
    cpu_read(RB + 16'd0, v);
    check("busy_write_ignored", v, 8'h45);

    // Abort together with start: no transfer.
    cpu_write(RB + 16'd5, 8'h81);
    repeat (6) @(negedge clk);
    cpu_read(RB + 16'd5, v);
    check("abort_start_status", v, 8'h00);

    // Clear pulse on the completing edge loses to the set.
    program_regs(16'h0400, 16'h8100, 8'd1);
    push_expected(16'h0400, 16'h8100, 1, 1'b0, 1'b0);
    cpu_write(RB + 16'd5, 8'h01);
    repeat (2) @(negedge clk);
    clear_done();
    check("clr_same_edge_done", done_flag, 1'b1);
    clear_done();
    check("clr_next_cycle_done", done_flag, 1'b0);
    check("clr_queue", expq.size(), 0);

    // Reset during CAP abandons the transfer.
    program_regs(16'h0500, 16'h8200, 8'd4);
    cpu_write(RB + 16'd5, 8'h01);
    @(negedge clk);
    check("cap_stall_before_rst", cpu_stall, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_cap_stall", cpu_stall, 1'b0);
    check("rst_cap_w_en", bus_w_en, cpu_w_en);
    check("rst_cap_addr", bus_address, cpu_address);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_cap_done", done_flag, 1'b0);
    check_regs_zero("rst_cap");

    // Randomised transfers.
    for (int t = 0; t < 6; t++) begin
      s  = 16'($urandom_range(0, 16'h0EFF));
      d  = 16'h8000 + 16'($urandom_range(0, 16'h3F00));
      l  = 8'($urandom_range(1, 12));
      hs = 1'($urandom_range(0, 1));
      hd = 1'($urandom_range(0, 1));
      n  = int'(l);
      program_regs(s, d, l);
      push_expected(s, d, n, hs, hd);
      cpu_write(RB + 16'd5, {5'b00000, hd, hs, 1'b1});
      wait_done(cyc);
      check("rand_cycles", cyc, 4 * n - 1);
      check("rand_queue", expq.size(), 0);
      cpu_read(RB + 16'd5, v);
      check("rand_status", v, 8'h01);
      clear_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
